pwm_cmd_ctrl: RTL
=================

Name: pwm_cmd_ctrl

Overview:
- Command controller between the UART receiver/transmitter and a bank of PWM generators.
- Parses framed byte commands arriving from the UART RX path and writes per-channel 8-bit duty registers.
- Answers each frame with an ACK, NAK or readback byte through the UART TX handshake.
- Replaces the single-byte "byte = duty" path, so one serial link can configure up to NUM_CH PWM channels safely.

Parameters:
- NUM_CH, 4, number of PWM channels (1..16).
- TIMEOUT_CYC, 2000000, inter-byte timeout in clk cycles (20 ms at 100 MHz); used only with CMD_TIMEOUT_EN.

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  synchronous reset, active-high.
- rx_data  in  8  received byte from UART RX.
- rx_valid  in  1  one-cycle strobe; rx_data valid.
- tx_busy  in  1  UART TX is sending; tx_start must not be pulsed while high.
- tx_data  out  8  response byte.
- tx_start  out  1  one-cycle request to UART TX.
- duty_bus  out  NUM_CH*8  duty registers; channel k at [8k+7:8k].
- duty_upd  out  NUM_CH  one-cycle pulse per channel written.
- busy  out  1  high in any state other than IDLE.
- err_pulse  out  1  one-cycle pulse on NAK, dropped byte or timeout.

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: duty_bus=0, duty_upd=0, tx_data=0x00, tx_start=0, err_pulse=0, busy=0, state=IDLE. Reset mid-frame or mid-response abandons the frame and sends no response.
- Frame format: SYNC(0xA5), ADDR, DUTY, CHK, where CHK = 0xA5 ^ ADDR ^ DUTY.
  - ADDR[7]=0: write. ADDR[7]=1: read.
  - ADDR[3:0]: channel. ADDR[6:4] is ignored.
- FSM states: IDLE, GET_ADDR, GET_DUTY, GET_CHK, EXEC, RESP.
- IDLE: rx_valid with 0xA5 -> GET_ADDR. Any other byte is silently discarded (no err_pulse).
- GET_ADDR -> GET_DUTY -> GET_CHK: each transition occurs on rx_valid and latches the byte.
  - Read frames still carry a DUTY byte; its value is ignored apart from the checksum.
- GET_CHK: on rx_valid -> EXEC.
- EXEC: lasts exactly one cycle, then -> RESP.
  - Bad checksum, or channel >= NUM_CH: tx_data=0x15 (NAK), err_pulse=1. No register changes.
  - Good write: duty register updated, duty_upd[ch]=1, tx_data=0x06 (ACK).
  - Good read: tx_data = current duty of ch.
  - Register, duty_upd and tx_data all change on the edge leaving EXEC. Latency from CHK rx_valid cycle N: duty visible at N+2.
- RESP: wait while tx_busy=1. In the first cycle with tx_busy=0, assert tx_start for exactly that cycle, then -> IDLE.
  - tx_data holds until the next EXEC.
- rx_valid arriving in EXEC or RESP: byte dropped, err_pulse=1, no state change. It is not treated as a new SYNC.
- 0xA5 received in GET_ADDR/GET_DUTY/GET_CHK is data, not a resync.
- Outputs duty_upd, tx_start and err_pulse are registered and never high for more than one cycle.
- Back-to-back frames are supported: a SYNC arriving the cycle after the tx_start cycle is accepted.

Optional Feature:
- Macro: CMD_TIMEOUT_EN.
- Defined: a counter runs in GET_ADDR/GET_DUTY/GET_CHK and clears on each accepted byte. When it reaches TIMEOUT_CYC-1 with no byte: state -> IDLE, err_pulse=1, no response byte, registers unchanged. The counter is held at 0 in other states.
- Undefined: no counter logic; a partial frame waits indefinitely.

Test Plan:
- rx bytes A5,02,80,27 with tx_busy=0 -> duty_bus[23:16]=0x80, duty_upd=0100 for one cycle, tx_start one pulse with tx_data=0x06.
- A5,02,80,00 (bad CHK) -> tx_data=0x15, err_pulse=1, duty_bus unchanged.
- Write ch1=0x40, then read frame A5,81,00,24 -> tx_data=0x40, duty_upd stays 0.
- Valid write with tx_busy held high 50 cycles -> tx_start asserted in the first cycle after tx_busy falls; an extra rx byte during the wait -> err_pulse and byte dropped. Assert rst during GET_DUTY -> all outputs zero, no tx_start.
- CMD_TIMEOUT_EN, TIMEOUT_CYC=100: send A5,01 then idle 100 cycles -> err_pulse, busy=0. Then A5,01,FF,5B -> duty ch1=0xFF, ACK.
- Channel out of range: NUM_CH=4, A5,05,10,B0 -> NAK, no duty_upd.

Source files
------------

// File: rtl/pwm_cmd_ctrl.sv
// Framed UART command parser that writes per-channel PWM duty registers and answers with ACK/NAK/readback.
// Optional inter-byte timeout is enabled by defining CMD_TIMEOUT_EN.
module pwm_cmd_ctrl #(
  parameter int NUM_CH      = 4,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  input  logic                tx_busy,
  output logic [7:0]          tx_data,
  output logic                tx_start,
  output logic [NUM_CH*8-1:0] duty_bus,
  output logic [NUM_CH-1:0]   duty_upd,
  output logic                busy,
  output logic                err_pulse
);

  localparam logic [7:0] SYNC = 8'hA5;
  localparam logic [7:0] ACK  = 8'h06;
  localparam logic [7:0] NAK  = 8'h15;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DUTY,
    GET_CHK,
    EXEC,
    RESP
  } state_t;

  state_t      state;
  state_t      state_nx;

  logic        rd_q;
  logic [3:0]  ch_q;
  logic [7:0]  duty_q;
  logic [7:0]  chk_acc;
  logic        in_frame;
  logic        timeout;

  logic        ch_ok;
  logic        frame_ok;
  logic        wr_en;
  logic [7:0]  rd_duty;
  logic [7:0]  resp_byte;
  logic        err_nx;
  logic        tx_start_nx;

  assign in_frame = (state == GET_ADDR) || (state == GET_DUTY) || (state == GET_CHK);

`ifdef CMD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] to_cnt;

  // Counts idle cycles between bytes of a partial frame; parked at 0 elsewhere.
  always_ff @(posedge clk) begin
    if (rst || !in_frame || rx_valid) begin
      to_cnt <= '0;
    end else if (!timeout) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign timeout = in_frame && !rx_valid && (to_cnt == CW'(TIMEOUT_CYC - 1));
`else
  // TIMEOUT_CYC only matters with the timeout build; this term is always false.
  assign timeout = 1'b0 && (TIMEOUT_CYC > 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (rx_valid && rx_data == SYNC) state_nx = GET_ADDR;
      GET_ADDR: if (timeout) state_nx = IDLE; else if (rx_valid) state_nx = GET_DUTY;
      GET_DUTY: if (timeout) state_nx = IDLE; else if (rx_valid) state_nx = GET_CHK;
      GET_CHK:  if (timeout) state_nx = IDLE; else if (rx_valid) state_nx = EXEC;
      EXEC:     state_nx = RESP;
      RESP:     if (!tx_busy) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Running XOR of SYNC, ADDR, DUTY and CHK is zero exactly when the checksum is good.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q    <= 1'b0;
      ch_q    <= '0;
      duty_q  <= '0;
      chk_acc <= '0;
    end else if (rx_valid) begin
      case (state)
        IDLE: chk_acc <= SYNC;
        GET_ADDR: begin
          rd_q    <= rx_data[7];
          ch_q    <= rx_data[3:0];
          chk_acc <= chk_acc ^ rx_data;
        end
        GET_DUTY: begin
          duty_q  <= rx_data;
          chk_acc <= chk_acc ^ rx_data;
        end
        GET_CHK: chk_acc <= chk_acc ^ rx_data;
        default: ;
      endcase
    end
  end

  always_comb begin
    ch_ok    = {1'b0, ch_q} < 5'(NUM_CH);
    frame_ok = (chk_acc == 8'h00) && ch_ok;
    wr_en    = (state == EXEC) && frame_ok && !rd_q;
    rd_duty  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_q == 4'(k)) rd_duty = duty_bus[8*k +: 8];
    end
    if (!frame_ok) begin
      resp_byte = NAK;
    end else if (rd_q) begin
      resp_byte = rd_duty;
    end else begin
      resp_byte = ACK;
    end
    err_nx = ((state == EXEC) && !frame_ok) ||
             (rx_valid && ((state == EXEC) || (state == RESP))) ||
             timeout;
    tx_start_nx = (state == RESP) && !tx_busy;
    busy        = (state != IDLE);
  end

  // Error events in adjacent cycles merge so err_pulse never stretches past one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_bus  <= '0;
      duty_upd  <= '0;
      tx_data   <= 8'h00;
      tx_start  <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      duty_upd  <= '0;
      tx_start  <= tx_start_nx;
      err_pulse <= err_nx && !err_pulse;
      if (state == EXEC) tx_data <= resp_byte;
      for (int k = 0; k < NUM_CH; k++) begin
        if (wr_en && ch_q == 4'(k)) begin
          duty_bus[8*k +: 8] <= duty_q;
          duty_upd[k]        <= 1'b1;
        end
      end
    end
  end

endmodule
